// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM with memory wait-state handshake, stall, watchdog and illegal-opcode flag.
// Optional build macro: MULTICYCLE_JUMP_EN adds J/JAL decoding to the JUMP state.
module multicycle_control #(
    parameter int OP_WIDTH     = 6,
    parameter int ALU_OP_WIDTH = 3,
    parameter int MEM_TIMEOUT  = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [OP_WIDTH-1:0]     op,
    input  logic                    mem_ready,
    input  logic                    stall,
    output logic                    pc_write,
    output logic                    pc_write_cond_eq,
    output logic                    pc_write_cond_ne,
    output logic                    iord,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic                    ir_write,
    output logic                    mem_to_reg,
    output logic                    reg_dst,
    output logic                    reg_write,
    output logic                    alu_src_a,
    output logic [1:0]              alu_src_b,
    output logic [ALU_OP_WIDTH-1:0] alu_op,
    output logic [1:0]              pc_src,
    output logic [3:0]              state,
    output logic                    illegal_op,
    output logic                    mem_timeout
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10
    } state_t;

    localparam logic [OP_WIDTH-1:0] OP_R    = OP_WIDTH'(6'h00);
    localparam logic [OP_WIDTH-1:0] OP_INC  = OP_WIDTH'(6'h01);
    localparam logic [OP_WIDTH-1:0] OP_BEQ  = OP_WIDTH'(6'h04);
    localparam logic [OP_WIDTH-1:0] OP_BNE  = OP_WIDTH'(6'h05);
    localparam logic [OP_WIDTH-1:0] OP_ADDI = OP_WIDTH'(6'h08);
    localparam logic [OP_WIDTH-1:0] OP_ORI  = OP_WIDTH'(6'h0D);
    localparam logic [OP_WIDTH-1:0] OP_LUI  = OP_WIDTH'(6'h0F);
    localparam logic [OP_WIDTH-1:0] OP_LW   = OP_WIDTH'(6'h23);
    localparam logic [OP_WIDTH-1:0] OP_SW   = OP_WIDTH'(6'h2B);
`ifdef MULTICYCLE_JUMP_EN
    localparam logic [OP_WIDTH-1:0] OP_J    = OP_WIDTH'(6'h02);
    localparam logic [OP_WIDTH-1:0] OP_JAL  = OP_WIDTH'(6'h03);
`endif

    localparam logic [ALU_OP_WIDTH-1:0] ALU_R   = ALU_OP_WIDTH'(3'b111);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = ALU_OP_WIDTH'(3'b100);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OR  = ALU_OP_WIDTH'(3'b101);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_INC = ALU_OP_WIDTH'(3'b110);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_LUI = ALU_OP_WIDTH'(3'b011);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB = ALU_OP_WIDTH'(3'b001);

    localparam int                   CNT_WIDTH = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(MEM_TIMEOUT - 1);

    state_t                state_q;
    state_t                next_state;
    logic [OP_WIDTH-1:0]   op_q;
    logic [CNT_WIDTH-1:0]  wait_cnt;
    logic                  waiting;
    logic                  timeout_hit;
    logic                  illegal_hit;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        next_state  = state_q;
        waiting     = 1'b0;
        timeout_hit = 1'b0;
        illegal_hit = 1'b0;
        case (state_q)
            S_IDLE:   next_state = S_FETCH;
            S_FETCH:  if (mem_ready) next_state = S_DECODE; else waiting = 1'b1;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW:                             next_state = S_MEMADR;
                    OP_R, OP_ADDI, OP_ORI, OP_INC, OP_LUI:    next_state = S_EXEC;
                    OP_BEQ, OP_BNE:                           next_state = S_BRANCH;
`ifdef MULTICYCLE_JUMP_EN
                    OP_J, OP_JAL:                             next_state = S_JUMP;
`endif
                    default: begin
                        next_state  = S_FETCH;
                        illegal_hit = 1'b1;
                    end
                endcase
            end
            S_MEMADR: next_state = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) next_state = S_MEMWB; else waiting = 1'b1;
            S_MEMWR:  if (mem_ready) next_state = S_FETCH; else waiting = 1'b1;
            S_EXEC:   next_state = S_ALUWB;
            default:  next_state = S_FETCH;
        endcase
        // The watchdog fires on the wait cycle that would bring the count to MEM_TIMEOUT.
        if (waiting && wait_cnt == CNT_LAST) begin
            timeout_hit = 1'b1;
            next_state  = S_FETCH;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            wait_cnt    <= '0;
            illegal_op  <= 1'b0;
            mem_timeout <= 1'b0;
        end else if (stall) begin
            illegal_op  <= 1'b0;
            mem_timeout <= 1'b0;
        end else begin
            state_q     <= next_state;
            if (state_q == S_DECODE) op_q <= op;
            wait_cnt    <= (waiting && !timeout_hit) ? wait_cnt + 1'b1 : '0;
            illegal_op  <= illegal_hit;
            mem_timeout <= timeout_hit;
        end
    end

    assign state = state_q;

    // Outputs are decoded combinationally so FETCH enables can follow mem_ready and reset clears them at once.
    always_comb begin
        pc_write         = 1'b0;
        pc_write_cond_eq = 1'b0;
        pc_write_cond_ne = 1'b0;
        iord             = 1'b0;
        mem_read         = 1'b0;
        mem_write        = 1'b0;
        ir_write         = 1'b0;
        mem_to_reg       = 1'b0;
        reg_dst          = 1'b0;
        reg_write        = 1'b0;
        alu_src_a        = 1'b0;
        alu_src_b        = 2'b00;
        alu_op           = '0;
        pc_src           = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = ALU_ADD;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_op    = ALU_ADD;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = ALU_ADD;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = (op_q == OP_R) ? 2'b00 : 2'b10;
                case (op_q)
                    OP_R:    alu_op = ALU_R;
                    OP_ORI:  alu_op = ALU_OR;
                    OP_INC:  alu_op = ALU_INC;
                    OP_LUI:  alu_op = ALU_LUI;
                    default: alu_op = ALU_ADD;
                endcase
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = (op_q == OP_R);
            end
            S_BRANCH: begin
                alu_src_a        = 1'b1;
                alu_op           = ALU_SUB;
                pc_src           = 2'b01;
                pc_write_cond_eq = (op_q == OP_BEQ);
                pc_write_cond_ne = (op_q == OP_BNE);
            end
            S_JUMP: begin
`ifdef MULTICYCLE_JUMP_EN
                pc_write  = 1'b1;
                pc_src    = 2'b10;
                reg_write = (op_q == OP_JAL);
`endif
            end
            default: ;
        endcase
        if (stall) begin
            pc_write         = 1'b0;
            pc_write_cond_eq = 1'b0;
            pc_write_cond_ne = 1'b0;
            ir_write         = 1'b0;
            reg_write        = 1'b0;
            mem_write        = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus queues hand-written expected outputs per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_multicycle_control;

    typedef struct packed {
        logic [3:0] state;
        logic       pc_write;
        logic       cond_eq;
        logic       cond_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
        logic       illegal_op;
        logic       mem_timeout;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       mem_ready;
    logic       stall;
    logic       pc_write, pc_write_cond_eq, pc_write_cond_ne, iord, mem_read, mem_write;
    logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op, mem_timeout;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_op;
    logic [3:0] state;

    int checks   = 0;
    int failures = 0;
    obs_t  exp_q[$];
    string name_q[$];

    multicycle_control #(.OP_WIDTH(6), .ALU_OP_WIDTH(3), .MEM_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready), .stall(stall),
        .pc_write(pc_write), .pc_write_cond_eq(pc_write_cond_eq), .pc_write_cond_ne(pc_write_cond_ne),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src), .state(state),
        .illegal_op(illegal_op), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    function automatic obs_t st(input logic [3:0] s);
        obs_t o = '0;
        o.state = s;
        return o;
    endfunction

    function automatic obs_t fetch(input logic go);
        obs_t o = st(4'd1);
        o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.alu_op = 3'b100;
        o.ir_write = go;   o.pc_write = go;
        return o;
    endfunction

    function automatic obs_t decode();
        obs_t o = st(4'd2);
        o.alu_src_b = 2'b11; o.alu_op = 3'b100;
        return o;
    endfunction

    function automatic obs_t memadr();
        obs_t o = st(4'd3);
        o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_op = 3'b100;
        return o;
    endfunction

    function automatic obs_t memrd();
        obs_t o = st(4'd4);
        o.mem_read = 1'b1; o.iord = 1'b1;
        return o;
    endfunction

    function automatic obs_t memwb();
        obs_t o = st(4'd5);
        o.reg_write = 1'b1; o.mem_to_reg = 1'b1;
        return o;
    endfunction

    function automatic obs_t memwr(input logic we);
        obs_t o = st(4'd6);
        o.mem_write = we; o.iord = 1'b1;
        return o;
    endfunction

    function automatic obs_t exec(input logic [1:0] srcb, input logic [2:0] aop);
        obs_t o = st(4'd7);
        o.alu_src_a = 1'b1; o.alu_src_b = srcb; o.alu_op = aop;
        return o;
    endfunction

    function automatic obs_t aluwb(input logic dst, input logic we);
        obs_t o = st(4'd8);
        o.reg_dst = dst; o.reg_write = we;
        return o;
    endfunction

    function automatic obs_t branch(input logic eq, input logic ne);
        obs_t o = st(4'd9);
        o.alu_src_a = 1'b1; o.alu_op = 3'b001; o.pc_src = 2'b01;
        o.cond_eq = eq; o.cond_ne = ne;
        return o;
    endfunction

    task automatic check(input string nm, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected during that cycle.
    task automatic step(input logic rdy, input logic stl, input logic [5:0] opc,
                        input obs_t e, input string nm);
        mem_ready = rdy;
        stall     = stl;
        op        = opc;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t  e;
            obs_t  a;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = {state, pc_write, pc_write_cond_eq, pc_write_cond_ne, iord, mem_read, mem_write,
                 ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_src,
                 illegal_op, mem_timeout};
            check(n, a, e);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        obs_t e;
        reset = 1'b0; op = '0; mem_ready = 1'b0; stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        step(0, 0, 6'h00, st(4'd0), "reset_idle");
        reset = 1'b1;
        step(0, 0, 6'h00, st(4'd0), "idle_release");

        step(1, 0, 6'h00, fetch(1), "addi_fetch");
        step(0, 0, 6'h08, decode(), "addi_decode");
        step(0, 0, 6'h00, exec(2'b10, 3'b100), "addi_exec");
        step(0, 0, 6'h00, aluwb(0, 1), "addi_aluwb");

        step(1, 0, 6'h00, fetch(1), "lw_fetch");
        step(0, 0, 6'h23, decode(), "lw_decode");
        step(0, 0, 6'h00, memadr(), "lw_memadr");
        for (int i = 0; i < 4; i++) step(0, 0, 6'h00, memrd(), "lw_memrd_wait");
        step(1, 0, 6'h00, memrd(), "lw_memrd_ready");
        step(0, 0, 6'h00, memwb(), "lw_memwb");

        step(1, 0, 6'h00, fetch(1), "bne_fetch");
        step(0, 0, 6'h05, decode(), "bne_decode");
        step(0, 0, 6'h00, branch(0, 1), "bne_branch");
        step(1, 0, 6'h00, fetch(1), "beq_fetch");
        step(0, 0, 6'h04, decode(), "beq_decode");
        step(0, 0, 6'h00, branch(1, 0), "beq_branch");

        step(1, 0, 6'h00, fetch(1), "lui_fetch");
        step(0, 0, 6'h0F, decode(), "lui_decode");
        step(0, 0, 6'h00, exec(2'b10, 3'b011), "lui_exec");
        step(0, 0, 6'h00, aluwb(0, 1), "lui_aluwb");
        step(1, 0, 6'h00, fetch(1), "inc_fetch");
        step(0, 0, 6'h01, decode(), "inc_decode");
        step(0, 0, 6'h00, exec(2'b10, 3'b110), "inc_exec");
        step(0, 0, 6'h00, aluwb(0, 1), "inc_aluwb");

        // Illegal opcode, then eight unanswered FETCH cycles trip the watchdog.
        step(1, 0, 6'h00, fetch(1), "ill_fetch");
        step(0, 0, 6'h3F, decode(), "ill_decode");
        e = fetch(0); e.illegal_op = 1'b1;
        step(0, 0, 6'h00, e, "ill_pulse");
        for (int i = 0; i < 7; i++) step(0, 0, 6'h00, fetch(0), "fetch_wait");
        e = fetch(1); e.mem_timeout = 1'b1;
        step(1, 0, 6'h00, e, "timeout_pulse");

        step(0, 0, 6'h0D, decode(), "ori_decode");
        step(0, 0, 6'h00, exec(2'b10, 3'b101), "ori_exec");
        step(0, 0, 6'h00, aluwb(0, 1), "ori_aluwb");

        // mem_ready on the final allowed wait cycle completes normally.
        for (int i = 0; i < 7; i++) step(0, 0, 6'h00, fetch(0), "fetch_wait2");
        step(1, 0, 6'h00, fetch(1), "ready_wins");
        step(0, 0, 6'h00, decode(), "r_decode");
        step(0, 0, 6'h00, exec(2'b00, 3'b111), "r_exec");
        for (int i = 0; i < 3; i++) step(0, 1, 6'h00, aluwb(1, 0), "r_aluwb_stall");
        step(0, 0, 6'h00, aluwb(1, 1), "r_aluwb");

        for (int i = 0; i < 2; i++) step(1, 1, 6'h00, fetch(0), "fetch_stall");
        step(1, 0, 6'h00, fetch(1), "sw_fetch");
        step(0, 0, 6'h2B, decode(), "sw_decode");
        step(0, 0, 6'h00, memadr(), "sw_memadr");
        for (int i = 0; i < 2; i++) step(0, 0, 6'h00, memwr(1), "sw_memwr_wait");
        step(1, 1, 6'h00, memwr(0), "sw_memwr_stall");
        step(1, 0, 6'h00, memwr(1), "sw_memwr_ready");

        step(1, 0, 6'h00, fetch(1), "j_fetch");
        step(0, 0, 6'h02, decode(), "j_decode");
`ifdef MULTICYCLE_JUMP_EN
        e = st(4'd10); e.pc_write = 1'b1; e.pc_src = 2'b10;
        step(0, 0, 6'h00, e, "j_jump");
        step(1, 0, 6'h00, fetch(1), "jal_fetch");
        step(0, 0, 6'h03, decode(), "jal_decode");
        e.reg_write = 1'b1;
        step(0, 0, 6'h00, e, "jal_jump");
`else
        e = fetch(0); e.illegal_op = 1'b1;
        step(0, 0, 6'h00, e, "j_illegal");
        step(1, 0, 6'h00, fetch(1), "jal_fetch");
        step(0, 0, 6'h03, decode(), "jal_decode");
        step(0, 0, 6'h00, e, "jal_illegal");
`endif

        // Asynchronous reset in the middle of a memory read.
        step(1, 0, 6'h00, fetch(1), "lw2_fetch");
        step(0, 0, 6'h23, decode(), "lw2_decode");
        step(0, 0, 6'h00, memadr(), "lw2_memadr");
        step(0, 0, 6'h00, memrd(), "lw2_memrd");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step(0, 0, 6'h00, st(4'd0), "reset_mid_memrd");
        reset = 1'b1;
        step(0, 0, 6'h00, st(4'd0), "idle_release2");
        step(0, 0, 6'h00, fetch(0), "fetch_after_reset");

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expectations required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
